// File: rtl/vec_mac_accel.sv
// Memory-mapped lane-serial multiply/accumulate co-processor: element-wise multiply or dot product.
// One lane per cycle while busy; completion raises done and a one-cycle irq pulse.
module vec_mac_accel #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 32,
  parameter int CTR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              wr_en,
  input  logic              accel_select,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CTR_W-1:0]  ctr,
  output logic              irq
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int PROD_W = 2 * LANE_W;
  localparam logic [CTR_W-1:0] LAST_LANE = CTR_W'(LANES - 1);

  localparam logic [2:0] R_CTRL = 3'd0;
  localparam logic [2:0] R_CTR  = 3'd1;
  localparam logic [2:0] R_A    = 3'd2;
  localparam logic [2:0] R_B    = 3'd3;
  localparam logic [2:0] R_C    = 3'd4;
  localparam logic [2:0] R_ACC  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;
  logic [DATA_W-1:0]  c_reg;
  logic [ACC_W-1:0]   acc;
  logic [CTR_W-1:0]   counter;
  logic               mode_l;
  logic               signed_l;
  logic               done;
  logic               busy;

  logic [2:0] reg_sel;
  logic       wr;
  logic       ctrl_go;
  logic       ctrl_mode;
  logic       ctrl_signed;
  logic       ctrl_clr;
  logic       unused_addr;

  assign reg_sel     = addr[4:2];
  assign wr          = wr_en & accel_select;
  assign ctrl_go     = data_in[0];
  assign ctrl_mode   = data_in[1];
  assign ctrl_signed = data_in[2];
  assign ctrl_clr    = data_in[3];
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  // Current lane operands, selected by the cycle counter.
  logic [LANE_W-1:0] a_lane;
  logic [LANE_W-1:0] b_lane;

  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (counter == CTR_W'(i)) begin
        a_lane = a_reg[i*LANE_W +: LANE_W];
        b_lane = b_reg[i*LANE_W +: LANE_W];
      end
    end
  end

  logic signed [PROD_W-1:0] prod_s;
  logic        [PROD_W-1:0] prod_u;
  logic        [ACC_W-1:0]  prod_ext;

  // Low LANE_W bits of the product are identical for signed and unsigned operands.
  always_comb begin
    prod_s   = PROD_W'($signed(a_lane)) * PROD_W'($signed(b_lane));
    prod_u   = PROD_W'(a_lane) * PROD_W'(b_lane);
    prod_ext = signed_l ? ACC_W'(prod_s) : ACC_W'(prod_u);
  end

  logic [DATA_W-1:0] c_next;

  always_comb begin
    c_next = c_reg;
    for (int i = 0; i < LANES; i++) begin
      if (counter == CTR_W'(i)) begin
        c_next[i*LANE_W +: LANE_W] = prod_u[LANE_W-1:0];
      end
    end
  end

  logic [CTR_W-1:0] counter_inc;

  assign counter_inc = (counter == {CTR_W{1'b1}}) ? counter : counter + CTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      acc      <= '0;
      counter  <= '0;
      mode_l   <= 1'b0;
      signed_l <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (wr && reg_sel == R_A) a_reg <= data_in;
          if (wr && reg_sel == R_B) b_reg <= data_in;
          if (wr && reg_sel == R_CTRL) begin
            if (ctrl_clr) acc <= '0;
            if (ctrl_go) begin
              state    <= RUN;
              mode_l   <= ctrl_mode;
              signed_l <= ctrl_signed;
              counter  <= '0;
              done     <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mode_l) acc   <= acc + prod_ext;
          else        c_reg <= c_next;
          counter <= counter_inc;
          if (counter == LAST_LANE) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            irq   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] acc_rd;

  generate
    if (ACC_W >= DATA_W) begin : g_acc_trunc
      assign acc_rd = acc[DATA_W-1:0];
    end else begin : g_acc_ext
      assign acc_rd = signed_l ? DATA_W'($signed(acc)) : DATA_W'(acc);
    end
  endgenerate

  logic [DATA_W-1:0] ctrl_rd;

  always_comb begin
    ctrl_rd           = '0;
    ctrl_rd[DATA_W-1] = done;
    ctrl_rd[DATA_W-2] = busy;
    ctrl_rd[2]        = signed_l;
    ctrl_rd[1]        = mode_l;
  end

  always_comb begin
    data_out = '0;
    case (reg_sel)
      R_CTRL:  data_out = ctrl_rd;
      R_CTR:   data_out = DATA_W'(counter);
      R_A:     data_out = a_reg;
      R_B:     data_out = b_reg;
      R_C:     data_out = c_reg;
      R_ACC:   data_out = acc_rd;
      default: data_out = '0;
    endcase
  end

  assign ctr = counter;

endmodule
